sram_arbiter: RTL and testbench
===============================

// Module: sram_arbiter
// PURPOSE
//  Shares the single-port program/data SRAM (sram: write, addr, in, out) among three requesters:
//  the UART program loader, the core's instruction fetch, and the core's data (tape) access.
//  Sequences every SRAM cycle, applies fixed loader priority plus round-robin fetch/data, and
//  returns read data with a one-cycle ack. Sits in top between usb_uart/uart_recv, core and sram.
// PARAMETERS
//  ADDR_WIDTH  10  SRAM address width
//  DATA_WIDTH   8  SRAM word width
// PORTS
//  clock       in   1    system clock, rising edge
//  reset       in   1    asynchronous, active-low reset
//  load_mode   in   1    1 = program-load phase; only loader requests are granted
//  ld_req      in   1    loader request; held until ld_ack
//  ld_write    in   1    loader op: 1 = write, 0 = read
//  ld_addr     in   AW   loader address
//  ld_wdata    in   DW   loader write data
//  ld_ack      out  1    one-cycle completion pulse to loader
//  if_req      in   1    instruction-fetch read request; held until if_ack
//  if_addr     in   AW   fetch address
//  if_ack      out  1    one-cycle completion pulse, rdata valid
//  dt_req      in   1    data request; held until dt_ack
//  dt_write    in   1    data op: 1 = write, 0 = read
//  dt_addr     in   AW   data address
//  dt_wdata    in   DW   data write data
//  dt_ack      out  1    one-cycle completion pulse
//  rdata       out  DW   read data; valid in the cycle any read ack is high, held otherwise
//  busy        out  1    1 whenever state != IDLE
//  sram_write  out  1    to sram write enable
//  sram_addr   out  AW   to sram address
//  sram_in     out  DW   to sram write data
//  sram_out    in   DW   from sram; registered, valid one clock after address edge
// BEHAVIOUR
//  - All outputs registered. Reset: state=IDLE, all acks=0, sram_write=0, sram_addr=0,
//    sram_in=0, rdata=0, busy=0, rr_last=DATA (so fetch wins first tie).
//  - FSM: IDLE -> WR -> DONE -> IDLE (write); IDLE -> RD_A -> RD_D -> DONE -> IDLE (read).
//    IDLE: sample reqs at edge; if winner, latch id and drive sram_addr/sram_in, set sram_write=1
//    for writes (WR) or 0 for reads (RD_A). WR: SRAM writes at this edge; clear sram_write.
//    RD_A: SRAM registers read. RD_D: capture sram_out into rdata. DONE: winner's ack=1 for
//    exactly this cycle; next edge unconditionally IDLE (requester drops req on the ack edge).
//  - Latency from req seen at edge T0: write ack high in cycle after T1 (2 cycles); read ack and
//    rdata in cycle after T2 (3 cycles). Throughput: write 3 cycles, read 4 cycles per access.
//  - Priority: ld_req > round-robin(if, dt). rr_last updated only on fetch/data grants.
//  - load_mode=1: if_req/dt_req ignored (never granted); load_mode=0: ld_req still granted.
//  - load_mode change mid-transaction does not abort; it affects next IDLE decision only.
//  - Requests are never granted while busy; changes to a granted requester's addr/data after
//    the IDLE edge are ignored (values latched). Fetch is read-only: no write path.
//  - sram_write high for exactly one cycle per write; never high outside WR.
//  - Address wraps naturally at 2^AW; no range checks.
//  - Async reset mid-operation: immediately IDLE, sram_write=0, no ack; pending op is lost and
//    must be reissued; a write interrupted in WR may or may not have landed.
// STRUCTURE
//  - sram_arb_pkg: state encoding (IDLE, WR, RD_A, RD_D, DONE), requester ids
//    (ID_LD, ID_IF, ID_DT), default widths.
//  - One combinational sub-module sram_arb_pick: (load_mode, reqs, rr_last) -> valid, winner id.
//  - Datapath: 3:1 mux on addr/wdata/write selected by winner, registered into sram ports.
// TESTING
//  1 Reset: reset=0 mid-WR -> next cycle sram_write=0, busy=0, no ack; all outputs at reset.
//  2 Loader write addr 0x00F data 0x41, then read 0x00F -> sram_write pulse 1 cycle, ld_ack
//    2 cycles after req; read ld_ack 3 cycles after req with rdata=0x41.
//  3 load_mode=1, if_req+dt_req+ld_req all high -> only ld granted; if/dt acks stay 0 until
//    load_mode=0.
//  4 load_mode=0, if_req and dt_req held high continuously -> grants alternate IF,DT,IF,DT;
//    first grant IF; each ack once per 4 cycles (reads).
//  5 dt write 0x2B to 0x3FF, dt read 0x3FF, if read 0x3FF -> both reads return 0x2B;
//    address 0x3FF+1 from requester drives sram_addr=0x000.
//  6 ld_req asserted while dt read in RD_D -> dt completes first, ld granted at next IDLE.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: state and requester encodings plus default widths for the SRAM arbiter
package sram_arb_pkg;
  localparam int AW_DEF = 10;
  localparam int DW_DEF = 8;
  typedef enum logic [2:0] {IDLE, WR, RD_A, RD_D, DONE} state_t;
  typedef enum logic [1:0] {ID_LD, ID_IF, ID_DT} id_t;
  function automatic logic [2:0] ack_vec(id_t id);
    return {id == ID_LD, id == ID_IF, id == ID_DT};
  endfunction
endpackage

// File: rtl/sram_arb_pick.sv
// sram_arb_pick: loader has fixed priority; fetch and data alternate when both are waiting
module sram_arb_pick
  import sram_arb_pkg::*;
(
  input  logic load_mode,
  input  logic ld_req,
  input  logic if_req,
  input  logic dt_req,
  input  id_t  rr_last,
  output logic valid,
  output id_t  id
);
  logic if_ok, dt_ok;
  always_comb begin
    if_ok = !load_mode && if_req;
    dt_ok = !load_mode && dt_req;
    valid = ld_req || if_ok || dt_ok;
    id = ld_req ? ID_LD : (if_ok && (!dt_ok || rr_last == ID_DT)) ? ID_IF : ID_DT;
  end
endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: sequences single-port SRAM cycles for the loader, instruction fetch and data port
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = AW_DEF,
  parameter int DATA_WIDTH = DW_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load_mode,
  input  logic                  ld_req,
  input  logic                  ld_write,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_wdata,
  output logic                  ld_ack,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_ack,
  input  logic                  dt_req,
  input  logic                  dt_write,
  input  logic [ADDR_WIDTH-1:0] dt_addr,
  input  logic [DATA_WIDTH-1:0] dt_wdata,
  output logic                  dt_ack,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic                  sram_write,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_in,
  input  logic [DATA_WIDTH-1:0] sram_out
);
  state_t state;
  id_t win, rr_last, pick_id;
  logic pick_valid, sel_write;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  sram_arb_pick u_pick (
    .load_mode(load_mode),
    .ld_req(ld_req),
    .if_req(if_req),
    .dt_req(dt_req),
    .rr_last(rr_last),
    .valid(pick_valid),
    .id(pick_id)
  );

  // Fetch has no write path, so it always selects a read.
  always_comb begin
    sel_write = (pick_id == ID_LD) ? ld_write : (pick_id == ID_DT) ? dt_write : 1'b0;
    sel_addr = (pick_id == ID_LD) ? ld_addr : (pick_id == ID_IF) ? if_addr : dt_addr;
    sel_wdata = (pick_id == ID_LD) ? ld_wdata : dt_wdata;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      win <= ID_LD;
      rr_last <= ID_DT;
      {ld_ack, if_ack, dt_ack} <= 3'b000;
      busy <= 1'b0;
      sram_write <= 1'b0;
      sram_addr <= '0;
      sram_in <= '0;
      rdata <= '0;
    end else begin
      case (state)
        IDLE: if (pick_valid) begin
          state <= sel_write ? WR : RD_A;
          win <= pick_id;
          busy <= 1'b1;
          sram_write <= sel_write;
          sram_addr <= sel_addr;
          sram_in <= sel_wdata;
          if (pick_id != ID_LD) rr_last <= pick_id;
        end
        WR: begin
          state <= DONE;
          sram_write <= 1'b0;
          {ld_ack, if_ack, dt_ack} <= ack_vec(win);
        end
        RD_A: state <= RD_D;
        RD_D: begin
          state <= DONE;
          rdata <= sram_out;
          {ld_ack, if_ack, dt_ack} <= ack_vec(win);
        end
        default: begin
          state <= IDLE;
          busy <= 1'b0;
          sram_write <= 1'b0;
          {ld_ack, if_ack, dt_ack} <= 3'b000;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed scenarios plus random traffic checked against a shadow memory model
module tb_sram_arbiter;
  localparam int AW = 10;
  localparam int DW = 8;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic load_mode = 1'b0;
  logic ld_req = 1'b0, ld_write = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [DW-1:0] ld_wdata = '0;
  logic if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic dt_req = 1'b0, dt_write = 1'b0;
  logic [AW-1:0] dt_addr = '0;
  logic [DW-1:0] dt_wdata = '0;
  logic ld_ack, if_ack, dt_ack, busy, sram_write;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_in, rdata, sram_out;

  logic seed = 1'b1;
  logic [DW-1:0] mem [1024];
  logic [DW-1:0] ref_mem [1024];
  int vectors = 0, errs = 0, cyc = 0, wpulse = 0, nw = 0;
  int ack_id[$];
  int ack_cyc[$];
  logic [DW-1:0] ack_dat[$];
  logic pend [3];
  logic pwr [3];
  logic [AW-1:0] pa [3];
  logic [DW-1:0] pd [3];

  sram_arbiter dut (
    .clock(clock), .reset(reset), .load_mode(load_mode),
    .ld_req(ld_req), .ld_write(ld_write), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_ack(ld_ack),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
    .dt_req(dt_req), .dt_write(dt_write), .dt_addr(dt_addr), .dt_wdata(dt_wdata), .dt_ack(dt_ack),
    .rdata(rdata), .busy(busy), .sram_write(sram_write), .sram_addr(sram_addr),
    .sram_in(sram_in), .sram_out(sram_out)
  );

  always #5 clock = ~clock;

  function automatic logic [DW-1:0] seed_val(int a);
    return DW'(a * 37 + 11);
  endfunction

  // Single-port SRAM with registered read, seeded while seed is high
  always @(posedge clock) begin
    if (seed) for (int i = 0; i < 1024; i++) mem[i] <= seed_val(i);
    else if (sram_write) mem[sram_addr] <= sram_in;
    sram_out <= mem[sram_addr];
  end

  function automatic logic ack_of(int who);
    return who == 0 ? ld_ack : who == 1 ? if_ack : dt_ack;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
    if (sram_write) wpulse++;
    if (ld_ack) begin ack_id.push_back(0); ack_cyc.push_back(cyc); ack_dat.push_back(rdata); end
    if (if_ack) begin ack_id.push_back(1); ack_cyc.push_back(cyc); ack_dat.push_back(rdata); end
    if (dt_ack) begin ack_id.push_back(2); ack_cyc.push_back(cyc); ack_dat.push_back(rdata); end
    chk("ack_onehot", 32'($countones({ld_ack, if_ack, dt_ack}) <= 1), 1);
  endtask

  task automatic drive(input int who, input logic r, input logic wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    case (who)
      0: begin ld_req = r; ld_write = wr; ld_addr = a; ld_wdata = d; end
      1: begin if_req = r; if_addr = a; end
      default: begin dt_req = r; dt_write = wr; dt_addr = a; dt_wdata = d; end
    endcase
  endtask

  // One complete transaction: latency in cycles, address seen on the SRAM at grant, read data
  task automatic xact(input int who, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      output int lat, output logic [AW-1:0] ga, output logic [DW-1:0] rd);
    drive(who, 1'b1, wr, a, d);
    lat = 0;
    ga = '0;
    do begin
      tick();
      lat++;
      if (lat == 1) ga = sram_addr;
    end while (!ack_of(who) && lat < 20);
    rd = rdata;
    if (wr) ref_mem[a] = d;
    drive(who, 1'b0, 1'b0, '0, '0);
    tick();
    chk("ack_one_cycle", 32'(ack_of(who)), 0);
  endtask

  task automatic service();
    for (int r = 0; r < 3; r++)
      if (ack_of(r)) begin
        chk("rnd_ack_pending", 32'(pend[r]), 1);
        if (pwr[r]) begin
          ref_mem[pa[r]] = pd[r];
          nw++;
        end else chk("rnd_rdata", 32'(rdata), 32'(ref_mem[pa[r]]));
        pend[r] = 1'b0;
        drive(r, 1'b0, 1'b0, '0, '0);
      end
  endtask

  initial begin
    int lat, n0, n1, c1, w0, bound;
    logic [AW-1:0] ga, a;
    logic [DW-1:0] rd;
    for (int i = 0; i < 1024; i++) ref_mem[i] = seed_val(i);
    for (int r = 0; r < 3; r++) begin pend[r] = 1'b0; pwr[r] = 1'b0; pa[r] = '0; pd[r] = '0; end
    tick();
    tick();
    seed = 1'b0;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_write", 32'(sram_write), 0);
    chk("rst_addr", 32'(sram_addr), 0);
    chk("rst_in", 32'(sram_in), 0);
    chk("rst_rdata", 32'(rdata), 0);
    chk("rst_acks", 32'({ld_ack, if_ack, dt_ack}), 0);
    reset = 1'b1;
    tick();

    // Reset asserted while a write is in WR
    drive(0, 1'b1, 1'b1, 10'h155, 8'h99);
    tick();
    chk("mid_wr_pulse", 32'(sram_write), 1);
    reset = 1'b0;
    #1;
    chk("mid_rst_write", 32'(sram_write), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    drive(0, 1'b0, 1'b0, '0, '0);
    tick();
    tick();
    chk("mid_rst_acks", 32'({ld_ack, if_ack, dt_ack}), 0);
    chk("mid_rst_addr", 32'(sram_addr), 0);
    reset = 1'b1;
    tick();
    xact(0, 1'b1, 10'h155, 8'h3C, lat, ga, rd);
    chk("reissue_lat", lat, 2);

    // Loader write then read back
    w0 = wpulse;
    xact(0, 1'b1, 10'h00F, 8'h41, lat, ga, rd);
    chk("ld_wr_lat", lat, 2);
    chk("ld_wr_pulse", wpulse - w0, 1);
    chk("ld_wr_addr", 32'(ga), 32'h00F);
    xact(0, 1'b0, 10'h00F, 8'h00, lat, ga, rd);
    chk("ld_rd_lat", lat, 3);
    chk("ld_rd_data", 32'(rd), 32'h41);

    // load_mode gates fetch/data while the loader keeps working
    load_mode = 1'b1;
    drive(1, 1'b1, 1'b0, 10'h00F, 8'h00);
    drive(2, 1'b1, 1'b0, 10'h0F0, 8'h00);
    n0 = ack_id.size();
    xact(0, 1'b1, 10'h0F0, 8'h77, lat, ga, rd);
    chk("lm_ld_wr_lat", lat, 2);
    xact(0, 1'b0, 10'h00F, 8'h00, lat, ga, rd);
    chk("lm_ld_rd_data", 32'(rd), 32'h41);
    repeat (4) tick();
    n1 = 0;
    for (int k = n0; k < ack_id.size(); k++) if (ack_id[k] != 0) n1++;
    chk("lm_no_if_dt_ack", n1, 0);

    // Fetch and data held high: strict alternation starting with fetch, one read per 4 cycles
    load_mode = 1'b0;
    n1 = ack_id.size();
    c1 = cyc;
    repeat (26) tick();
    chk("rr_count", 32'(ack_id.size() - n1 >= 6), 1);
    chk("rr_first_lat", ack_cyc[n1] - c1, 3);
    for (int k = 0; k < 6; k++) begin
      chk("rr_order", ack_id[n1 + k], (k % 2 == 0) ? 1 : 2);
      chk("rr_data", 32'(ack_dat[n1 + k]), (k % 2 == 0) ? 32'h41 : 32'h77);
      if (k > 0) chk("rr_spacing", ack_cyc[n1 + k] - ack_cyc[n1 + k - 1], 4);
    end
    drive(1, 1'b0, 1'b0, '0, '0);
    drive(2, 1'b0, 1'b0, '0, '0);
    bound = 0;
    do begin tick(); bound++; end while ((busy || ld_ack || if_ack || dt_ack) && bound < 10);
    chk("rr_drain", 32'(busy), 0);

    // Data write/read and fetch read at the top address, then wrap to zero
    xact(2, 1'b1, 10'h3FF, 8'h2B, lat, ga, rd);
    chk("dt_wr_lat", lat, 2);
    xact(2, 1'b0, 10'h3FF, 8'h00, lat, ga, rd);
    chk("dt_rd_lat", lat, 3);
    chk("dt_rd_data", 32'(rd), 32'h2B);
    xact(1, 1'b0, 10'h3FF, 8'h00, lat, ga, rd);
    chk("if_rd_data", 32'(rd), 32'h2B);
    a = 10'h3FF;
    a = a + 1'b1;
    xact(2, 1'b0, a, 8'h00, lat, ga, rd);
    chk("wrap_addr", 32'(ga), 0);
    chk("wrap_data", 32'(rd), 32'(ref_mem[0]));

    // Loader request arriving during a data read in RD_D waits for the next IDLE
    drive(2, 1'b1, 1'b0, 10'h0F0, 8'h00);
    tick();
    tick();
    drive(0, 1'b1, 1'b0, 10'h3FF, 8'h00);
    tick();
    chk("late_dt_ack", 32'(dt_ack), 1);
    chk("late_ld_ack", 32'(ld_ack), 0);
    chk("late_dt_data", 32'(rdata), 32'h77);
    drive(2, 1'b0, 1'b0, '0, '0);
    lat = 0;
    do begin tick(); lat++; end while (!ld_ack && lat < 20);
    chk("late_ld_lat", lat, 4);
    chk("late_ld_data", 32'(rdata), 32'h2B);
    drive(0, 1'b0, 1'b0, '0, '0);
    tick();

    // Random traffic from all three requesters against the shadow memory
    w0 = wpulse;
    nw = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 150) load_mode = ($urandom_range(0, 3) == 0);
      if (c % 200 == 0) load_mode = 1'b0;
      for (int r = 0; r < 3; r++)
        if (!pend[r] && $urandom_range(0, 3) == 0) begin
          pwr[r] = (r != 1) && ($urandom_range(0, 1) == 1);
          pa[r] = AW'($urandom);
          pd[r] = DW'($urandom);
          pend[r] = 1'b1;
          drive(r, 1'b1, pwr[r], pa[r], pd[r]);
        end
      tick();
      service();
    end
    load_mode = 1'b0;
    bound = 0;
    while ((pend[0] || pend[1] || pend[2] || busy) && bound < 100) begin
      tick();
      service();
      bound++;
    end
    chk("rnd_drain", 32'({pend[0], pend[1], pend[2], busy}), 0);
    chk("rnd_write_pulses", wpulse - w0, nw);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
